// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory request arbiter.
// Tag layout on the memory side is {client_id, client_tag}.
package mem_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WDATA = 1'b1
    } arb_state_e;

    // A single-client build still needs a 1-bit ID field to keep vectors legal.
    function automatic int id_bits(input int n_clients);
        return (n_clients > 1) ? $clog2(n_clients) : 1;
    endfunction

    function automatic int m_tag_bits(input int tag_bits, input int n_clients);
        return tag_bits + id_bits(n_clients);
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces both a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges N client memory channels onto one memory port: round-robin commands,
// write-grant lock until the data beat is taken, tag-steered responses.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_CLIENTS  = 2,
    parameter int ADDR_BITS  = 28,
    parameter int DATA_BITS  = 128,
    parameter int TAG_BITS   = 4,
    localparam int ID_BITS    = id_bits(N_CLIENTS),
    localparam int M_TAG_BITS = m_tag_bits(TAG_BITS, N_CLIENTS),
    localparam int MASK_BITS  = DATA_BITS / 8
) (
    input  logic                            clk,
    input  logic                            reset,

    input  logic [N_CLIENTS-1:0]            c_req_valid,
    output logic [N_CLIENTS-1:0]            c_req_ready,
    input  logic [N_CLIENTS-1:0]            c_req_rw,
    input  logic [N_CLIENTS*ADDR_BITS-1:0]  c_req_addr,
    input  logic [N_CLIENTS*TAG_BITS-1:0]   c_req_tag,
    input  logic [N_CLIENTS-1:0]            c_req_data_valid,
    output logic [N_CLIENTS-1:0]            c_req_data_ready,
    input  logic [N_CLIENTS*DATA_BITS-1:0]  c_req_data_bits,
    input  logic [N_CLIENTS*MASK_BITS-1:0]  c_req_data_mask,
    output logic [N_CLIENTS-1:0]            c_resp_valid,
    output logic [N_CLIENTS*TAG_BITS-1:0]   c_resp_tag,
    output logic [N_CLIENTS*DATA_BITS-1:0]  c_resp_data,

    output logic                            m_req_valid,
    input  logic                            m_req_ready,
    output logic                            m_req_rw,
    output logic [ADDR_BITS-1:0]            m_req_addr,
    output logic [M_TAG_BITS-1:0]           m_req_tag,
    output logic                            m_req_data_valid,
    input  logic                            m_req_data_ready,
    output logic [DATA_BITS-1:0]            m_req_data_bits,
    output logic [MASK_BITS-1:0]            m_req_data_mask,
    input  logic                            m_resp_valid,
    input  logic [M_TAG_BITS-1:0]           m_resp_tag,
    input  logic [DATA_BITS-1:0]            m_resp_data
);

    arb_state_e           state, state_nxt;
    logic [ID_BITS-1:0]   rr_ptr, rr_ptr_nxt;
    logic [ID_BITS-1:0]   owner, owner_nxt;

    logic [N_CLIENTS-1:0] arb_req;
    logic [N_CLIENTS-1:0] grant;
    logic [ID_BITS-1:0]   gidx;
    logic                 gany;
    logic                 cmd_phase;
    logic                 data_phase;
    logic                 cmd_fire;
    logic                 data_fire;
    logic [ID_BITS-1:0]   resp_id;

    // reset is active-low and gates every handshake output while asserted.
    assign cmd_phase  = reset && (state == S_IDLE);
    assign data_phase = reset && (state == S_WDATA);
    assign arb_req    = cmd_phase ? c_req_valid : '0;

    rr_arbiter #(
        .N  (N_CLIENTS),
        .IW (ID_BITS)
    ) u_rr (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // Command and write-data payloads are pure muxes; only valid/ready are gated.
    assign m_req_rw        = c_req_rw[gidx];
    assign m_req_addr      = c_req_addr[slice_lo(int'(gidx), ADDR_BITS) +: ADDR_BITS];
    assign m_req_tag       = {gidx, c_req_tag[slice_lo(int'(gidx), TAG_BITS) +: TAG_BITS]};
    assign m_req_data_bits = c_req_data_bits[slice_lo(int'(owner), DATA_BITS) +: DATA_BITS];
    assign m_req_data_mask = c_req_data_mask[slice_lo(int'(owner), MASK_BITS) +: MASK_BITS];

    assign cmd_fire  = m_req_valid && m_req_ready;
    assign data_fire = m_req_data_valid && m_req_data_ready;

    always_comb begin
        state_nxt        = state;
        rr_ptr_nxt       = rr_ptr;
        owner_nxt        = owner;
        m_req_valid      = 1'b0;
        c_req_ready      = '0;
        m_req_data_valid = 1'b0;
        c_req_data_ready = '0;
        if (cmd_phase) begin
            m_req_valid = gany;
            c_req_ready = m_req_ready ? grant : '0;
            if (cmd_fire) begin
                rr_ptr_nxt = (gidx == ID_BITS'(N_CLIENTS - 1)) ? '0 : gidx + 1'b1;
                if (m_req_rw) begin
                    owner_nxt = gidx;
                    state_nxt = S_WDATA;
                end
            end
        end else if (data_phase) begin
            m_req_data_valid        = c_req_data_valid[owner];
            c_req_data_ready[owner] = m_req_data_ready;
            if (data_fire) begin
                state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // Responses bypass the FSM; an ID with no matching client simply matches nothing.
    assign resp_id = m_resp_tag[M_TAG_BITS-1 -: ID_BITS];

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_resp
        assign c_resp_valid[i] = reset && m_resp_valid && (resp_id == ID_BITS'(i));
        assign c_resp_tag[slice_lo(i, TAG_BITS) +: TAG_BITS]    = m_resp_tag[TAG_BITS-1:0];
        assign c_resp_data[slice_lo(i, DATA_BITS) +: DATA_BITS] = m_resp_data;
    end

endmodule
